// File: rtl/spcpu_bus_responder_pkg.sv
// Shared types for the spcpu data-bus responder: access size encoding,
// the posted-write buffer entry and lane masks.
package spcpu_bus_responder_pkg;

    typedef enum logic {
        cpu_data_acc_sz_8  = 1'b0,
        cpu_data_acc_sz_16 = 1'b1
    } cpu_data_acc_sz_e;

    typedef struct packed {
        logic [14:0] hw_index;
        logic [1:0]  mask;
        logic [15:0] data;
    } cpu_wbuf_entry;

    localparam logic [1:0] cpu_byte_mask_hi   = 2'b10;
    localparam logic [1:0] cpu_byte_mask_lo   = 2'b01;
    localparam logic [1:0] cpu_byte_mask_full = 2'b11;

    // A 2-byte store still needs a one-bit halfword index.
    function automatic int hw_index_width(input int mem_bytes_log2);
        return (mem_bytes_log2 > 1) ? mem_bytes_log2 - 1 : 1;
    endfunction

endpackage

// File: rtl/spcpu_bus_responder_if.sv
// Initiator-side request signals of the spcpu data bus (address, size, direction).
interface spcpu_bus_responder_if;
    import spcpu_bus_responder_pkg::*;

    logic [15:0]       data_inout_addr;
    cpu_data_acc_sz_e  data_acc_sz;
    logic              data_inout_we;

    modport master (
        output data_inout_addr,
        output data_acc_sz,
        output data_inout_we
    );

    modport slave (
        input data_inout_addr,
        input data_acc_sz,
        input data_inout_we
    );

endinterface

// File: rtl/spcpu_resp_ram.sv
// Halfword backing store: async read, full-word preload port and a byte-masked
// commit port; the commit is written last so it wins on a shared index.
module spcpu_resp_ram #(
    parameter int IDX_W = 11
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_index,
    output logic [15:0]      rd_data,
    input  logic             commit_en,
    input  logic [IDX_W-1:0] commit_index,
    input  logic [1:0]       commit_mask,
    input  logic [15:0]      commit_data,
    input  logic             preload_en,
    input  logic [IDX_W-1:0] preload_index,
    input  logic [15:0]      preload_data
);

    logic [15:0] mem [2**IDX_W];

    assign rd_data = mem[rd_index];

    always_ff @(posedge clk) begin
        if (preload_en) begin
            mem[preload_index] <= preload_data;
        end
        if (commit_en) begin
            if (commit_mask[1]) begin
                mem[commit_index][15:8] <= commit_data[15:8];
            end
            if (commit_mask[0]) begin
                mem[commit_index][7:0] <= commit_data[7:0];
            end
        end
    end

endmodule

// File: rtl/spcpu_bus_responder.sv
// Memory-side responder for the spcpu data bus: combinational reads, a one-entry
// posted write buffer with read-after-write forwarding, sticky error flags.
module spcpu_bus_responder
    import spcpu_bus_responder_pkg::*;
#(
    parameter  int MEM_BYTES_LOG2 = 12,
    localparam int IDX_W          = hw_index_width(MEM_BYTES_LOG2)
) (
    input  logic                    clk,
    input  logic                    reset,
    spcpu_bus_responder_if.slave    bus,
    inout  wire  [15:0]             data_inout,
    input  logic                    load_we,
    input  logic [IDX_W-1:0]        load_hw_addr,
    input  logic [15:0]             load_data,
    output logic [15:0]             wr_count,
    output logic                    misalign_err,
    output logic                    range_err
);

    logic [15:0]      addr;
    logic             size16;
    logic [IDX_W-1:0] idx;
    logic             range_bad;
    logic             misalign;
    logic             access_bad;
    logic             write_take;
    logic [15:0]      ram_rdata;
    logic [15:0]      merged;
    logic [15:0]      rd_data;
    logic             fwd_hit;
    logic             wbuf_valid;
    cpu_wbuf_entry    wbuf;
    cpu_wbuf_entry    new_entry;

    assign addr       = bus.data_inout_addr;
    assign size16     = (bus.data_acc_sz == cpu_data_acc_sz_16);
    assign idx        = IDX_W'(addr >> 1);
    assign range_bad  = ((32'(addr) >> MEM_BYTES_LOG2) != 32'd0);
    assign misalign   = size16 && addr[0];
    assign access_bad = range_bad || misalign;
    assign write_take = bus.data_inout_we && !access_bad;

    spcpu_resp_ram #(
        .IDX_W(IDX_W)
    ) u_ram (
        .clk           (clk),
        .rd_index      (idx),
        .rd_data       (ram_rdata),
        .commit_en     (wbuf_valid),
        .commit_index  (wbuf.hw_index[IDX_W-1:0]),
        .commit_mask   (wbuf.mask),
        .commit_data   (wbuf.data),
        .preload_en    (load_we),
        .preload_index (load_hw_addr),
        .preload_data  (load_data)
    );

    // A buffered write not yet in the array must still be visible to reads.
    assign fwd_hit = wbuf_valid && (wbuf.hw_index == 15'(idx));

    always_comb begin
        merged = ram_rdata;
        if (fwd_hit && wbuf.mask[1]) begin
            merged[15:8] = wbuf.data[15:8];
        end
        if (fwd_hit && wbuf.mask[0]) begin
            merged[7:0] = wbuf.data[7:0];
        end
    end

    always_comb begin
        rd_data = 16'h0000;
        if (!access_bad) begin
            if (size16) begin
                rd_data = merged;
            end else begin
                rd_data = {8'h00, (addr[0] ? merged[7:0] : merged[15:8])};
            end
        end
    end

    assign data_inout = bus.data_inout_we ? 16'hzzzz : rd_data;

    // Byte stores replicate the low lane so the mask alone picks the target byte.
    always_comb begin
        new_entry.hw_index = 15'(idx);
        if (size16) begin
            new_entry.mask = cpu_byte_mask_full;
            new_entry.data = data_inout;
        end else begin
            new_entry.mask = addr[0] ? cpu_byte_mask_lo : cpu_byte_mask_hi;
            new_entry.data = {data_inout[7:0], data_inout[7:0]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbuf_valid   <= 1'b0;
            wbuf         <= '0;
            wr_count     <= 16'd0;
            misalign_err <= 1'b0;
            range_err    <= 1'b0;
        end else begin
            wbuf_valid <= write_take;
            if (write_take) begin
                wbuf <= new_entry;
            end
            if (wbuf_valid) begin
                wr_count <= wr_count + 16'd1;
            end
            if (misalign) begin
                misalign_err <= 1'b1;
            end
            if (range_bad) begin
                range_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spcpu_bus_responder.sv
// Self-checking bench for spcpu_bus_responder against a byte-level memory model.
`timescale 1ns/1ps
module tb_spcpu_bus_responder;
    import spcpu_bus_responder_pkg::*;

    localparam int MEM_BYTES_LOG2 = 12;
    localparam int MEM_BYTES      = 2**MEM_BYTES_LOG2;
    localparam int IDX_W          = MEM_BYTES_LOG2 - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_we;
    logic [IDX_W-1:0]  load_hw_addr;
    logic [15:0]       load_data;
    logic [15:0]       wr_count;
    logic              misalign_err;
    logic              range_err;
    logic [15:0]       cpu_wdata;
    wire  [15:0]       data_inout;

    spcpu_bus_responder_if bus ();

    assign data_inout = bus.data_inout_we ? cpu_wdata : 16'hzzzz;

    spcpu_bus_responder #(
        .MEM_BYTES_LOG2(MEM_BYTES_LOG2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .data_inout   (data_inout),
        .load_we      (load_we),
        .load_hw_addr (load_hw_addr),
        .load_data    (load_data),
        .wr_count     (wr_count),
        .misalign_err (misalign_err),
        .range_err    (range_err)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Byte-addressed model; the last accepted write stays pending until the
    // following posedge so an async reset can still discard it.
    logic [7:0]  m_mem [MEM_BYTES];
    int          pend_n;
    logic [15:0] pend_addr [2];
    logic [7:0]  pend_val  [2];
    logic [15:0] m_count;
    logic        m_mis;
    logic        m_rng;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [15:0] a);
        for (int i = 0; i < pend_n; i++) begin
            if (pend_addr[i] == a) return pend_val[i];
        end
        return m_mem[a[MEM_BYTES_LOG2-1:0]];
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a, input logic sz16);
        if (int'(a) >= MEM_BYTES || (sz16 && a[0])) return 16'h0000;
        if (sz16) return {byte_at(a), byte_at(a + 16'd1)};
        return {8'h00, byte_at(a)};
    endfunction

    task automatic model_posedge(input logic we, input logic sz16, input logic [15:0] a, input logic [15:0] d);
        logic bad;
        bad = (int'(a) >= MEM_BYTES) || (sz16 && a[0]);
        if (int'(a) >= MEM_BYTES) m_rng = 1'b1;
        if (sz16 && a[0]) m_mis = 1'b1;
        if (load_we) begin
            m_mem[2*int'(load_hw_addr)]     = load_data[15:8];
            m_mem[2*int'(load_hw_addr) + 1] = load_data[7:0];
        end
        if (pend_n > 0) begin
            for (int i = 0; i < pend_n; i++) m_mem[pend_addr[i][MEM_BYTES_LOG2-1:0]] = pend_val[i];
            m_count = m_count + 16'd1;
        end
        pend_n = 0;
        if (we && !bad) begin
            if (sz16) begin
                pend_addr[0] = a;          pend_val[0] = d[15:8];
                pend_addr[1] = a + 16'd1;  pend_val[1] = d[7:0];
                pend_n = 2;
            end else begin
                pend_addr[0] = a;          pend_val[0] = d[7:0];
                pend_n = 1;
            end
        end
    endtask

    task automatic drive_bus(input logic we, input logic sz16, input logic [15:0] a, input logic [15:0] d);
        bus.data_inout_we   = we;
        bus.data_acc_sz     = sz16 ? cpu_data_acc_sz_16 : cpu_data_acc_sz_8;
        bus.data_inout_addr = a;
        cpu_wdata           = d;
    endtask

    // One bus cycle, entered and left just after a negedge.
    task automatic applyStimulus(input logic we, input logic sz16, input logic [15:0] a, input logic [15:0] d);
        drive_bus(we, sz16, a, d);
        #1;
        if (we) checkOutput("cpu_drive_no_contention", data_inout, d);
        else    checkOutput($sformatf("read_%h_sz%0d", a, sz16 ? 16 : 8), data_inout, model_read(a, sz16));
        @(posedge clk);
        model_posedge(we, sz16, a, d);
        @(negedge clk);
    endtask

    task automatic read_expect(input logic [15:0] a, input logic sz16, input logic [15:0] exp);
        drive_bus(1'b0, sz16, a, 16'h0000);
        #1;
        checkOutput($sformatf("directed_read_%h", a), data_inout, exp);
        @(posedge clk);
        model_posedge(1'b0, sz16, a, 16'h0000);
        @(negedge clk);
    endtask

    task automatic check_status(input string tag);
        checkOutput({tag, "_wr_count"}, wr_count, m_count);
        checkOutput({tag, "_misalign_err"}, {15'd0, misalign_err}, {15'd0, m_mis});
        checkOutput({tag, "_range_err"}, {15'd0, range_err}, {15'd0, m_rng});
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] a;
        logic        we;
        logic        sz16;

        reset        = 1'b0;
        load_we      = 1'b0;
        load_hw_addr = '0;
        load_data    = 16'h0000;
        drive_bus(1'b0, 1'b1, 16'h0000, 16'h0000);
        pend_n  = 0;
        m_count = 16'd0;
        m_mis   = 1'b0;
        m_rng   = 1'b0;

        repeat (2) @(negedge clk);
        for (int i = 0; i < MEM_BYTES / 2; i++) begin
            load_we      = 1'b1;
            load_hw_addr = IDX_W'(i);
            load_data    = (i == 16) ? 16'hBEEF : 16'($urandom);
            @(posedge clk);
            m_mem[2*i]     = load_data[15:8];
            m_mem[2*i + 1] = load_data[7:0];
            @(negedge clk);
        end
        load_we = 1'b0;
        #1;
        checkOutput("reset_wr_count", wr_count, 16'd0);
        checkOutput("reset_misalign_err", {15'd0, misalign_err}, 16'd0);
        checkOutput("reset_range_err", {15'd0, range_err}, 16'd0);
        reset = 1'b1;

        read_expect(16'h0020, 1'b1, 16'hBEEF);
        read_expect(16'h0021, 1'b0, 16'h00EF);

        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h005A);
        read_expect(16'h0020, 1'b1, 16'h5AEF);
        applyStimulus(1'b0, 1'b1, 16'h0100, 16'h0000);
        read_expect(16'h0020, 1'b1, 16'h5AEF);
        checkOutput("single_write_count", wr_count, 16'd1);

        applyStimulus(1'b1, 1'b1, 16'h0040, 16'h1111);
        applyStimulus(1'b1, 1'b1, 16'h0042, 16'h2222);
        applyStimulus(1'b1, 1'b1, 16'h0040, 16'h3333);
        read_expect(16'h0040, 1'b1, 16'h3333);
        read_expect(16'h0042, 1'b1, 16'h2222);
        checkOutput("burst_write_count", wr_count, 16'd4);
        checkOutput("no_misalign_yet", {15'd0, misalign_err}, 16'd0);

        applyStimulus(1'b1, 1'b1, 16'h0041, 16'hFFFF);
        checkOutput("misalign_flag", {15'd0, misalign_err}, 16'd1);
        read_expect(16'h0040, 1'b1, 16'h3333);
        read_expect(16'h0041, 1'b1, 16'h0000);
        checkOutput("misalign_not_counted", wr_count, 16'd4);
        read_expect(16'h0FFF, 1'b0, {8'h00, m_mem[12'hFFF]});
        checkOutput("last_byte_in_range", {15'd0, range_err}, 16'd0);
        read_expect(16'h2000, 1'b0, 16'h0000);
        checkOutput("range_flag", {15'd0, range_err}, 16'd1);

        applyStimulus(1'b1, 1'b0, 16'h0060, 16'h0077);
        load_we      = 1'b1;
        load_hw_addr = IDX_W'(16'h0030);
        load_data    = 16'h1234;
        applyStimulus(1'b0, 1'b1, 16'h0062, 16'h0000);
        load_we = 1'b0;
        read_expect(16'h0060, 1'b1, 16'h7734);
        check_status("after_collision");

        applyStimulus(1'b1, 1'b1, 16'h0050, 16'hAAAA);
        drive_bus(1'b0, 1'b1, 16'h0000, 16'h0000);
        #2;
        reset   = 1'b0;
        pend_n  = 0;
        m_count = 16'd0;
        m_mis   = 1'b0;
        m_rng   = 1'b0;
        #1;
        check_status("async_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 16'h0050, 16'h0000);
        check_status("after_reset_release");

        for (int n = 0; n < 400; n++) begin
            we   = ($urandom_range(0, 2) == 0);
            sz16 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) a = 16'($urandom_range(MEM_BYTES, 65535));
            else                            a = 16'($urandom_range(0, MEM_BYTES - 1));
            applyStimulus(we, sz16, a, 16'($urandom));
            check_status("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
